// File: rtl/thread_issue_scheduler_pkg.sv
// Shared thread-scheduling types: thread id, virtual pointer and per-thread state.
package thread_issue_scheduler_pkg;

   localparam int n_threads = 4;
   localparam int TID_W     = $clog2(n_threads);

   typedef logic [TID_W-1:0] threadid_t;
   typedef logic [31:0]      vptr_t;

   typedef enum logic {TS_READY, TS_INFLIGHT} tstate_t;

endpackage : thread_issue_scheduler_pkg

// File: rtl/thread_issue_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after i_ptr,
// wrapping from N-1 back to 0. Grant index is 0 when nothing requests.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic             o_gnt_valid,
   output logic [IDX_W-1:0] o_gnt_idx
);

   always_comb begin
      // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
      o_gnt_valid = 1'b0;
      o_gnt_idx   = '0;
      for (int off = 0; off < N; off++) begin
         automatic int idx = (int'(i_ptr) + off) % N;
         if (!o_gnt_valid && i_req[IDX_W'(idx)]) begin
            o_gnt_valid = 1'b1;
            o_gnt_idx   = IDX_W'(idx);
         end
      end
   end

endmodule : rr_arbiter

// File: rtl/thread_issue_scheduler.sv
// Picks the next hardware thread to issue into fetch (one instruction in flight per thread),
// tracks each thread until WB completion or watchdog expiry, and enforces the exception lock.
module thread_issue_scheduler
   import thread_issue_scheduler_pkg::*;
#(
   parameter int N_THREADS = n_threads,
   parameter int TIMEOUT   = 64,
   parameter int CNT_W     = $clog2(TIMEOUT + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_THREADS-1:0] thread_enable,
   input  vptr_t                pc [N_THREADS],
   output logic                 issue_valid,
   input  logic                 issue_ready,
   output threadid_t            issue_thread,
   output vptr_t                issue_pc,
   input  logic                 wb_done,
   input  threadid_t            wb_thread,
   input  logic                 exc_enter,
   input  threadid_t            exc_thread,
   input  logic                 exc_exit,
   output logic                 exc_locked,
   output threadid_t            exc_master,
   output logic [N_THREADS-1:0] timeout,
   output logic [N_THREADS-1:0] busy
);

   tstate_t          r_state [N_THREADS];
   logic [CNT_W-1:0] r_cnt   [N_THREADS];
   tstate_t          w_state_nxt [N_THREADS];
   logic [CNT_W-1:0] w_cnt_nxt   [N_THREADS];

   logic      r_exc_locked;
   threadid_t r_exc_master;
   threadid_t r_rr_ptr;

   logic [N_THREADS-1:0] w_elig;
   logic                 w_gnt_valid;
   threadid_t            w_gnt_idx;
   logic                 w_xfer;

   // Eligibility, busy and watchdog pulses depend only on registered state and inputs.
   // An out-of-range wb_thread matches no thread index, so it is ignored naturally.
   always_comb begin
      w_elig  = '0;
      busy    = '0;
      timeout = '0;
      for (int t = 0; t < N_THREADS; t++) begin
         automatic logic hit      = wb_done && (wb_thread == threadid_t'(t));
         automatic logic inflight = (r_state[t] == TS_INFLIGHT);
         busy[t]    = inflight;
         timeout[t] = inflight && (r_cnt[t] == CNT_W'(TIMEOUT - 1)) && !hit;
         w_elig[t]  = !inflight && thread_enable[t] &&
                      (!r_exc_locked || (r_exc_master == threadid_t'(t)));
      end
   end

   rr_arbiter #(
      .N     (N_THREADS),
      .IDX_W ($bits(threadid_t))
   ) u_arb (
      .i_req       (w_elig),
      .i_ptr       (r_rr_ptr),
      .o_gnt_valid (w_gnt_valid),
      .o_gnt_idx   (w_gnt_idx)
   );

   assign issue_valid  = w_gnt_valid;
   assign issue_thread = w_gnt_idx;
   assign issue_pc     = w_gnt_valid ? pc[w_gnt_idx] : '0;
   assign w_xfer       = w_gnt_valid && issue_ready;

   assign exc_locked = r_exc_locked;
   assign exc_master = r_exc_master;

   // Per-thread next state; WB completion and watchdog both return the thread to READY.
   always_comb begin
      for (int t = 0; t < N_THREADS; t++) begin
         automatic logic hit = wb_done && (wb_thread == threadid_t'(t));
         w_state_nxt[t] = r_state[t];
         w_cnt_nxt[t]   = r_cnt[t];
         case (r_state[t])
            TS_READY: begin
               if (w_xfer && (w_gnt_idx == threadid_t'(t))) begin
                  w_state_nxt[t] = TS_INFLIGHT;
                  w_cnt_nxt[t]   = '0;
               end
            end
            TS_INFLIGHT: begin
               if (hit || (r_cnt[t] == CNT_W'(TIMEOUT - 1))) begin
                  w_state_nxt[t] = TS_READY;
                  w_cnt_nxt[t]   = '0;
               end else begin
                  w_cnt_nxt[t] = r_cnt[t] + CNT_W'(1);
               end
            end
            default: begin
               w_state_nxt[t] = TS_READY;
               w_cnt_nxt[t]   = '0;
            end
         endcase
      end
   end

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int t = 0; t < N_THREADS; t++) begin
            r_state[t] <= TS_READY;
            r_cnt[t]   <= '0;
         end
      end else begin
         for (int t = 0; t < N_THREADS; t++) begin
            r_state[t] <= w_state_nxt[t];
            r_cnt[t]   <= w_cnt_nxt[t];
         end
      end
   end

   // Exit takes priority over enter while locked; enter while locked is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_exc_locked <= 1'b0;
         r_exc_master <= '0;
      end else if (r_exc_locked) begin
         if (exc_exit) begin
            r_exc_locked <= 1'b0;
         end
      end else if (exc_enter) begin
         r_exc_locked <= 1'b1;
         r_exc_master <= exc_thread;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_ptr <= '0;
      end else if (w_xfer) begin
         r_rr_ptr <= (w_gnt_idx == threadid_t'(N_THREADS - 1)) ? '0 : w_gnt_idx + threadid_t'(1);
      end
   end

endmodule : thread_issue_scheduler
